alu_mc: RTL
===========

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the operand and result width (minimum 8, power of two).
REQ-002 The block SHALL have parameter OPCODE_LENGTH, default 5, giving the Operation width.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state is rising-edge triggered.
REQ-004 The block SHALL have port reset, input, 1 bit, an asynchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning the operands and Operation are valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts an operation this cycle.
REQ-007 The block SHALL have ports SrcA and SrcB, input, DATA_WIDTH each, carrying the operands.
REQ-008 The block SHALL have port Operation, input, OPCODE_LENGTH, carrying the opcode.
REQ-009 The block SHALL have port out_valid, output, 1 bit, meaning ALUResult is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit, meaning the consumer takes the result.
REQ-011 The block SHALL have port ALUResult, output, DATA_WIDTH, carrying the registered result.
REQ-012 The block SHALL have port Zero, output, 1 bit, asserted when the registered ALUResult equals 0.

Function
REQ-013 An operation SHALL be accepted only on a rising edge where in_valid and in_ready are both 1.
REQ-014 in_ready SHALL equal (state==IDLE) and (out_valid==0 or out_ready==1).
REQ-015 Opcodes 0x00-0x0D SHALL keep the base codes: AND 0, OR 1, ADD 2, XOR 3, SLL 4, SRL 5, SUB 6, SRA 7, EQ 8, GE 9, LT 0xC, NE 0xD; compare ops SHALL return 1 or 0.
REQ-016 The block SHALL add SLTU 0x0E (unsigned less-than, 1 or 0) and GEU 0x0F (unsigned greater-or-equal, 1 or 0).
REQ-017 All shifts SHALL use only SrcB[$clog2(DATA_WIDTH)-1:0] as the shift amount.
REQ-018 Undefined opcodes SHALL produce 0 with single-op latency.
REQ-019 Single-cycle ops SHALL set out_valid on the edge after acceptance, so back-to-back throughput is one per cycle while out_ready=1.
REQ-020 MUL 0x10, MULH 0x11, MULHSU 0x12 and MULHU 0x13 SHALL form the 2*DATA_WIDTH product and return the low half (MUL) or the high half (others), with 1-cycle latency.
REQ-021 DIV 0x14, DIVU 0x15, REM 0x16 and REMU 0x17 SHALL run a restoring radix-2 divide in the DIV_BUSY state for DATA_WIDTH cycles, with out_valid rising DATA_WIDTH+1 edges after acceptance.
REQ-022 Division by zero SHALL give a quotient of all ones and a remainder equal to SrcA.
REQ-023 Signed overflow (most-negative / -1) SHALL give a quotient equal to SrcA and a remainder of 0.
REQ-024 The FSM SHALL have state IDLE, moving to DIV_BUSY on acceptance of a divide op.
REQ-025 The FSM SHALL have state DIV_BUSY, moving to IDLE after the last iteration while loading ALUResult and setting out_valid.
REQ-026 While out_valid=1 and out_ready=0, ALUResult, Zero and out_valid SHALL hold stable.
REQ-027 Input changes while in_ready=0 SHALL be ignored.
REQ-028 A result SHALL be consumed on an edge with out_valid=1 and out_ready=1; if a new op is accepted on the same edge, out_valid SHALL stay 1 with the new single-cycle result, otherwise out_valid SHALL drop to 0.

Reset
REQ-029 reset SHALL asynchronously force state=IDLE, out_valid=0, ALUResult=0 and Zero=1, with in_ready=1 after reset release.
REQ-030 reset asserted during DIV_BUSY SHALL abort the division with no result emitted.

Configuration
REQ-031 With ALU_MULDIV_EN defined, opcodes 0x10-0x17 SHALL behave as in REQ-020 to REQ-023.
REQ-032 Without ALU_MULDIV_EN, opcodes 0x10-0x17 SHALL be treated as undefined (result 0, 1-cycle), DIV_BUSY SHALL be unreachable, and no multiplier or divider logic SHALL be present.

Structure
REQ-033 Package alu_pkg SHALL hold the opcode enum alu_op_e, the FSM state enum alu_state_e and the localparam DIV_CYCLES.
REQ-034 The iterative divider SHALL be sub-module alu_divider, with start/busy/done signals, signed/unsigned mode and quotient/remainder outputs, instantiated only under ALU_MULDIV_EN.

Verification
REQ-035 Reset then ADD 7+(-3) with out_ready=1 SHALL give out_valid the next cycle, ALUResult=4 and Zero=0.
REQ-036 SRA of 0x80000000 by SrcB=0x21 SHALL give 0xC0000000 (amount 1); SLTU 1 vs 0xFFFFFFFF SHALL give 1.
REQ-037 MULH of 0xFFFFFFFF by 0xFFFFFFFF SHALL give 0; MULHU of the same operands SHALL give 0xFFFFFFFE.
REQ-038 DIV -7/2 SHALL give -3 and REM -7/2 SHALL give -1, with out_valid 33 edges after acceptance and in_ready=0 throughout.
REQ-039 DIVU 5/0 SHALL give 0xFFFFFFFF; REM 5/0 SHALL give 5; DIV 0x80000000/-1 SHALL give 0x80000000.
REQ-040 Holding out_ready=0 for 5 cycles SHALL keep the result stable with in_ready=0; reset asserted mid-divide SHALL leave out_valid=0 and in_ready=1 after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the multi-cycle ALU (alu_mc).
package alu_pkg;

  // Width of the decoded opcode field; alu_mc needs OPCODE_LENGTH >= ALU_OP_W.
  localparam int ALU_OP_W = 5;

  // Divider iterations for the default 32-bit datapath (one quotient bit per cycle).
  localparam int DIV_CYCLES = 32;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_AND    = 5'h00,
    OP_OR     = 5'h01,
    OP_ADD    = 5'h02,
    OP_XOR    = 5'h03,
    OP_SLL    = 5'h04,
    OP_SRL    = 5'h05,
    OP_SUB    = 5'h06,
    OP_SRA    = 5'h07,
    OP_EQ     = 5'h08,
    OP_GE     = 5'h09,
    OP_LT     = 5'h0C,
    OP_NE     = 5'h0D,
    OP_SLTU   = 5'h0E,
    OP_GEU    = 5'h0F,
    OP_MUL    = 5'h10,
    OP_MULH   = 5'h11,
    OP_MULHSU = 5'h12,
    OP_MULHU  = 5'h13,
    OP_DIV    = 5'h14,
    OP_DIVU   = 5'h15,
    OP_REM    = 5'h16,
    OP_REMU   = 5'h17
  } alu_op_e;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    DIV_BUSY = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_divider.sv
// Iterative restoring radix-2 divider, one quotient bit per cycle.
// Operates on magnitudes and fixes signs at the output; divide-by-zero and
// signed overflow are flagged at start and override the iterated result.
module alu_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_CYCLES
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_a;
  logic [CW-1:0]    r_count;
  logic             r_busy;
  logic             r_done;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div0;
  logic             r_ovf;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;

  // Operand magnitudes and the trial subtraction for the current iteration.
  always_comb begin
    w_a_neg = i_signed & i_dividend[WIDTH-1];
    w_b_neg = i_signed & i_divisor[WIDTH-1];
    w_a_abs = w_a_neg ? -i_dividend : i_dividend;
    w_b_abs = w_b_neg ? -i_divisor : i_divisor;
    w_shift = {r_rem, r_q[WIDTH-1]};
    w_ge    = (w_shift >= {1'b0, r_dvs});
    w_diff  = w_shift[WIDTH-1:0] - r_dvs;
  end

  // Load on start, then shift/subtract with a down-counter; done pulses once.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q     <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_a     <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_div0  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (i_start) begin
      r_q     <= w_a_abs;
      r_rem   <= '0;
      r_dvs   <= w_b_abs;
      r_a     <= i_dividend;
      r_count <= CW'(WIDTH);
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      r_div0  <= (i_divisor == '0);
      r_ovf   <= i_signed && (i_dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (i_divisor == '1);
    end else if (r_busy) begin
      r_rem   <= w_ge ? w_diff : w_shift[WIDTH-1:0];
      r_q     <= {r_q[WIDTH-2:0], w_ge};
      r_count <= r_count - 1'b1;
      if (r_count == CW'(1)) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  // Sign correction and special-case override of the final result.
  always_comb begin
    if (r_div0) begin
      o_quotient  = '1;
      o_remainder = r_a;
    end else if (r_ovf) begin
      o_quotient  = r_a;
      o_remainder = '0;
    end else begin
      o_quotient  = r_neg_q ? -r_q : r_q;
      o_remainder = r_neg_r ? -r_rem : r_rem;
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake on both sides.
// Single-cycle ops (and multiplies) register their result on the edge after
// acceptance. Optional feature macro: ALU_MULDIV_EN enables MUL*/DIV*/REM*
// (0x10-0x17); without it those opcodes decode as undefined and return 0.
module alu_mc
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUResult,
  output logic                     Zero
);

  localparam int SH_W = $clog2(DATA_WIDTH);

  alu_state_e            r_state;
  alu_state_e            w_state_nxt;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_zero;
  logic                  r_out_valid;

  logic [ALU_OP_W-1:0]   w_op;
  logic                  w_hi_zero;
  logic [SH_W-1:0]       w_sh;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_alu_res;
  logic                  w_start_div;
  logic                  w_div_done;
  logic [DATA_WIDTH-1:0] w_div_res;

  // Opcodes with any bit set above the decoded field are undefined.
  assign w_op      = Operation[ALU_OP_W-1:0];
  assign w_hi_zero = ((Operation >> ALU_OP_W) == '0);
  assign w_sh      = SrcB[SH_W-1:0];
  assign in_ready  = (r_state == IDLE) && (!r_out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;

`ifdef ALU_MULDIV_EN
  logic [2*DATA_WIDTH-1:0] w_mul_a;
  logic [2*DATA_WIDTH-1:0] w_mul_b;
  logic [2*DATA_WIDTH-1:0] w_prod;
  logic                    w_is_div;
  logic                    w_div_busy;
  logic                    w_div_fin;
  logic [DATA_WIDTH-1:0]   w_quo;
  logic [DATA_WIDTH-1:0]   w_rem;
  logic                    r_div_rem;

  // One shared multiplier; operand extension picks the signedness per opcode.
  always_comb begin
    w_mul_a = ((w_op == OP_MULH) || (w_op == OP_MULHSU)) ?
              {{DATA_WIDTH{SrcA[DATA_WIDTH-1]}}, SrcA} : {{DATA_WIDTH{1'b0}}, SrcA};
    w_mul_b = (w_op == OP_MULH) ?
              {{DATA_WIDTH{SrcB[DATA_WIDTH-1]}}, SrcB} : {{DATA_WIDTH{1'b0}}, SrcB};
    w_prod  = w_mul_a * w_mul_b;
  end

  assign w_is_div    = w_hi_zero && (w_op >= OP_DIV) && (w_op <= OP_REMU);
  assign w_start_div = w_accept && w_is_div;
  assign w_div_done  = w_div_fin && !w_div_busy;
  assign w_div_res   = r_div_rem ? w_rem : w_quo;

  alu_divider #(
    .WIDTH(DATA_WIDTH)
  ) u_div (
    .i_clk       (clk),
    .i_rst       (reset),
    .i_start     (w_start_div),
    .i_signed    ((w_op == OP_DIV) || (w_op == OP_REM)),
    .i_dividend  (SrcA),
    .i_divisor   (SrcB),
    .o_busy      (w_div_busy),
    .o_done      (w_div_fin),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  // Remember whether the running divide wants the remainder or the quotient.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_rem <= 1'b0;
    end else if (w_start_div) begin
      r_div_rem <= (w_op == OP_REM) || (w_op == OP_REMU);
    end
  end
`else
  assign w_start_div = 1'b0;
  assign w_div_done  = 1'b0;
  assign w_div_res   = '0;
`endif

  // Combinational result for every opcode that completes in one cycle.
  always_comb begin
    w_alu_res = '0;
    if (w_hi_zero) begin
      case (w_op)
        OP_AND:  w_alu_res = SrcA & SrcB;
        OP_OR:   w_alu_res = SrcA | SrcB;
        OP_ADD:  w_alu_res = SrcA + SrcB;
        OP_XOR:  w_alu_res = SrcA ^ SrcB;
        OP_SLL:  w_alu_res = SrcA << w_sh;
        OP_SRL:  w_alu_res = SrcA >> w_sh;
        OP_SUB:  w_alu_res = SrcA - SrcB;
        OP_SRA:  w_alu_res = $unsigned($signed(SrcA) >>> w_sh);
        OP_EQ:   w_alu_res = DATA_WIDTH'(SrcA == SrcB);
        OP_GE:   w_alu_res = DATA_WIDTH'($signed(SrcA) >= $signed(SrcB));
        OP_LT:   w_alu_res = DATA_WIDTH'($signed(SrcA) < $signed(SrcB));
        OP_NE:   w_alu_res = DATA_WIDTH'(SrcA != SrcB);
        OP_SLTU: w_alu_res = DATA_WIDTH'(SrcA < SrcB);
        OP_GEU:  w_alu_res = DATA_WIDTH'(SrcA >= SrcB);
`ifdef ALU_MULDIV_EN
        OP_MUL:  w_alu_res = w_prod[DATA_WIDTH-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU:
                 w_alu_res = w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
`endif
        default: w_alu_res = '0;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state: park in DIV_BUSY until the divider reports completion.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (w_start_div) w_state_nxt = DIV_BUSY;
      DIV_BUSY: if (w_div_done)  w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  // Output register: load on single-cycle accept or divide completion, else
  // drop valid once consumed; holds everything while back-pressured.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result    <= '0;
      r_zero      <= 1'b1;
      r_out_valid <= 1'b0;
    end else if (w_accept && !w_start_div) begin
      r_result    <= w_alu_res;
      r_zero      <= (w_alu_res == '0);
      r_out_valid <= 1'b1;
    end else if (w_div_done) begin
      r_result    <= w_div_res;
      r_zero      <= (w_div_res == '0);
      r_out_valid <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign ALUResult = r_result;
  assign Zero      = r_zero;

endmodule
